// File: rtl/erm16_io_bridge.sv
// erm16_io_bridge: splits ERM16 core traffic between external memory and a 4-register I/O space
// (TX FIFO, synchronized input port, status, control). Optional: `define ERM16_IO_TXDONE_IRQ_EN.
module erm16_io_bridge #(
  parameter int FIFO_DEPTH = 8,
  parameter int DW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          wrmem,
  input  logic          ioe,
  input  logic          intreq,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_we,
  output logic [DW-1:0] cpu_di,
  input  logic [DW-1:0] in_port,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          int_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  localparam logic [1:0] A_TXDATA = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_INPORT = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [DW-1:0] fifo_mem [FIFO_DEPTH];

  logic          ioe_q, wr_q, intreq_q;
  logic          ovf, irq_pend, txdone, int_q;
  logic [DW-1:0] io_rdata_q, in_meta, in_sync;
  logic [DW-1:0] regsel;

  logic empty, full;
  logic io_wr, push_req, push, pop, ctrl_wr;
  logic ovf_nxt, irq_nxt, txdone_nxt;

  // I/O space decodes only addr[1:0]; upper bits alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[DW-1:2];

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

  assign io_wr    = ioe & wrmem & ~wr_q;
  assign push_req = io_wr & (addr[1:0] == A_TXDATA);
  assign push     = push_req & ~full;
  assign pop      = ~empty & out_ready;
  assign ctrl_wr  = io_wr & (addr[1:0] == A_CTRL);

  // Set terms dominate clear terms for every sticky flag.
  assign ovf_nxt = (push_req & full) | (ovf & ~(ctrl_wr & wdata[0]));
  assign irq_nxt = (intreq & ~intreq_q) | (irq_pend & ~(ctrl_wr & wdata[1]));

`ifdef ERM16_IO_TXDONE_IRQ_EN
  assign txdone_nxt = (pop & ~push & ((rd_ptr + PTR_ONE) == wr_ptr))
                    | (txdone & ~(ctrl_wr & wdata[2]));
`else
  assign txdone_nxt = 1'b0;
`endif

  always_comb begin
    regsel = '0;
    case (addr[1:0])
      A_STATUS: regsel = {11'b0, txdone, ovf, irq_pend, full, empty};
      A_INPORT: regsel = in_sync;
      default:  regsel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ioe_q      <= 1'b0;
      io_rdata_q <= '0;
      // Holding wr_q high across reset keeps a still-asserted wrmem from counting as a new write.
      wr_q       <= wrmem;
      intreq_q   <= 1'b0;
      ovf        <= 1'b0;
      irq_pend   <= 1'b0;
      txdone     <= 1'b0;
      int_q      <= 1'b0;
      in_meta    <= '0;
      in_sync    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      ioe_q      <= ioe;
      io_rdata_q <= regsel;
      wr_q       <= wrmem;
      intreq_q   <= intreq;
      ovf        <= ovf_nxt;
      irq_pend   <= irq_nxt;
      txdone     <= txdone_nxt;
      int_q      <= irq_nxt | txdone_nxt;
      in_meta    <= in_port;
      in_sync    <= in_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= wdata;
  end

  assign mem_we    = wrmem & ~ioe;
  assign cpu_di    = ioe_q ? io_rdata_q : mem_rdata;
  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : fifo_mem[rd_idx];
  // Single flop drives the interrupt pin so it cannot glitch between flag updates.
  assign int_out   = int_q;

endmodule

// File: tb/tb_erm16_io_bridge.sv
// Directed self-checking bench for erm16_io_bridge; expectations follow the txdone build option.
module tb_erm16_io_bridge;

`ifdef ERM16_IO_TXDONE_IRQ_EN
  localparam logic TXD = 1'b1;
`else
  localparam logic TXD = 1'b0;
`endif
  localparam logic [15:0] TXB = TXD ? 16'h0010 : 16'h0000;

  logic        clk = 1'b0;
  logic        rst, wrmem, ioe, intreq, out_ready;
  logic [15:0] addr, wdata, mem_rdata, in_port;
  logic        mem_we, out_valid, int_out;
  logic [15:0] cpu_di, out_data;
  logic [15:0] rd;
  int checks = 0;
  int failures = 0;

  erm16_io_bridge #(.FIFO_DEPTH(8), .DW(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wrmem(wrmem), .ioe(ioe),
    .intreq(intreq), .mem_rdata(mem_rdata), .mem_we(mem_we), .cpu_di(cpu_di),
    .in_port(in_port), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .int_out(int_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic io_write(input logic [15:0] a, input logic [15:0] d);
    ioe = 1'b1; addr = a; wdata = d; wrmem = 1'b1;
    tick();
    wrmem = 1'b0;
    tick();
  endtask

  task automatic io_read(input logic [15:0] a, output logic [15:0] v);
    ioe = 1'b1; addr = a; wrmem = 1'b0;
    tick();
    v = cpu_di;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wrmem = 1'b0; ioe = 1'b0; intreq = 1'b0; out_ready = 1'b0;
    addr = 16'h0; wdata = 16'h0; mem_rdata = 16'hBEEF; in_port = 16'h0;
    tick(); tick();
    chk("rst_cpu_di", cpu_di, 16'hBEEF);
    chk("rst_out_valid", {15'b0, out_valid}, 16'h0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_int_out", {15'b0, int_out}, 16'h0);
    rst = 1'b0;
    tick();
    chk("mem_cpu_di", cpu_di, 16'hBEEF);
    chk("mem_we_idle", {15'b0, mem_we}, 16'h0);
    wrmem = 1'b1; #1;
    chk("mem_we_write", {15'b0, mem_we}, 16'h1);
    ioe = 1'b1; #1;
    chk("mem_we_io", {15'b0, mem_we}, 16'h0);
    wrmem = 1'b0; ioe = 1'b0;
    tick();

    // wrmem held three cycles must push exactly once
    ioe = 1'b1; addr = 16'h0; wdata = 16'h1234; wrmem = 1'b1;
    tick(); tick(); tick();
    wrmem = 1'b0;
    tick();
    chk("hold_out_valid", {15'b0, out_valid}, 16'h1);
    chk("hold_out_data", out_data, 16'h1234);
    pop_one();
    chk("hold_single_push", {15'b0, out_valid}, 16'h0);
    chk("txdone_first_pop", {15'b0, int_out}, {15'b0, TXD});
    io_write(16'h3, 16'h4);
    chk("txdone_clr", {15'b0, int_out}, 16'h0);

    // overflow: 9 writes into 8 entries
    for (int i = 1; i <= 9; i++) io_write(16'h0, 16'(i));
    io_read(16'h1, rd);
    chk("status_full_ovf", rd, 16'h000A);
    io_read(16'hFFF5, rd);
    chk("status_alias", rd, 16'h000A);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_valid", {15'b0, out_valid}, 16'h1);
      chk("drain_data", out_data, 16'(i));
      pop_one();
    end
    io_read(16'h1, rd);
    chk("status_empty_ovf", rd, 16'h0009 | TXB);
    io_write(16'h3, 16'h1);
    io_read(16'h1, rd);
    chk("status_ovf_clr", rd, 16'h0001 | TXB);
    io_write(16'h3, 16'h4);
    io_read(16'h1, rd);
    chk("status_clean", rd, 16'h0001);

    // full FIFO: simultaneous pop and push -> push dropped
    for (int i = 1; i <= 8; i++) io_write(16'h0, 16'h0100 + 16'(i));
    ioe = 1'b1; addr = 16'h0; wdata = 16'hFFFF; wrmem = 1'b1; out_ready = 1'b1;
    tick();
    wrmem = 1'b0; out_ready = 1'b0;
    tick();
    io_read(16'h1, rd);
    chk("full_pop_push_status", rd, 16'h0008);
    for (int i = 0; i < 7; i++) begin
      chk("fpp_drain_data", out_data, 16'h0102 + 16'(i));
      pop_one();
    end
    chk("fpp_seven_left", {15'b0, out_valid}, 16'h0);
    io_write(16'h3, 16'h5);
    io_read(16'h1, rd);
    chk("fpp_clr", rd, 16'h0001);

    // input synchronizer latency
    ioe = 1'b1; addr = 16'h2; in_port = 16'h00A5;
    tick(); tick();
    chk("inport_early", cpu_di, 16'h0000);
    tick();
    chk("inport_sync", cpu_di, 16'h00A5);

    // interrupt latch
    intreq = 1'b1; tick(); tick(); intreq = 1'b0; tick();
    chk("irq_int_out", {15'b0, int_out}, 16'h1);
    io_read(16'h1, rd);
    chk("irq_status", rd, 16'h0005);
    io_write(16'h3, 16'h2);
    chk("irq_clr_int", {15'b0, int_out}, 16'h0);
    io_read(16'h1, rd);
    chk("irq_clr_status", rd, 16'h0001);
    ioe = 1'b1; addr = 16'h3; wdata = 16'h2; wrmem = 1'b1; intreq = 1'b1;
    tick();
    wrmem = 1'b0; intreq = 1'b0;
    tick();
    chk("irq_set_wins", {15'b0, int_out}, 16'h1);
    io_write(16'h3, 16'h2);
    chk("irq_clr2", {15'b0, int_out}, 16'h0);

    // reset in the middle of a held write
    io_write(16'h0, 16'h7777);
    chk("pre_rst_valid", {15'b0, out_valid}, 16'h1);
    ioe = 1'b1; addr = 16'h0; wdata = 16'hAAAA; wrmem = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    wrmem = 1'b0;
    tick();
    chk("rst_mid_no_push", {15'b0, out_valid}, 16'h0);
    io_read(16'h1, rd);
    chk("rst_mid_status", rd, 16'h0001);

    // txdone: one word in, one word out
    io_write(16'h0, 16'h0042);
    pop_one();
    chk("txdone_int", {15'b0, int_out}, {15'b0, TXD});
    io_read(16'h1, rd);
    chk("txdone_status", rd, 16'h0001 | TXB);
    io_write(16'h3, 16'h4);
    chk("txdone_int_clr", {15'b0, int_out}, 16'h0);

    // back to memory space
    ioe = 1'b0; mem_rdata = 16'h1357;
    tick();
    chk("mem_return", cpu_di, 16'h1357);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
